hdb3_decoder: RTL and testbench

Receive-side HDB3 line decoder: consumes the two-rail P/N pulse stream produced by the HDB3 encoder and recovers the original NRZ bit stream. It detects bipolar violations (V) and removes both the V pulse and its preceding balancing pulse (B00V), then emits one NRZ bit per clock after a fixed pipeline delay. It also flags line-code errors. It sits directly downstream of the encoder, or of the line receiver in loopback test.

---
 rtl/hdb3_pkg.sv | 16 +
 rtl/hdb3_violation_det.sv | 67 ++++++
 rtl/hdb3_decoder.sv | 91 +++++++++
 tb/tb_hdb3_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared constants and helpers for the HDB3 receive path.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b10;
  localparam logic [1:0] SYM_NEG  = 2'b01;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  localparam int unsigned HDB3_PIPE_DEPTH = 4;
  localparam int unsigned HDB3_MAX_ZEROS  = 3;

  function automatic logic is_mark(input logic [1:0] sym);
    return (sym == SYM_POS) || (sym == SYM_NEG);
  endfunction

endpackage

// File: rtl/hdb3_violation_det.sv
// Symbol classification, polarity/V tracking and line-code error detection.
module hdb3_violation_det
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym,
  input  logic [1:0] sr_recent,
  output logic       mark,
  output logic       is_v,
  output logic       err
);

  localparam logic [2:0] ZeroRunErr = 3'(HDB3_MAX_ZEROS);
  localparam logic [2:0] ZeroRunSat = 3'(HDB3_MAX_ZEROS + 1);

  logic       mark_seen_q, mark_seen_d;
  logic       last_pol_q, last_pol_d;
  logic       v_seen_q, v_seen_d;
  logic       last_v_pol_q, last_v_pol_d;
  logic [2:0] zero_run_q, zero_run_d;
  logic       pol;
  logic       ill;

  always_comb begin
    mark = is_mark(sym);
    pol  = (sym == SYM_POS);
    ill  = (sym == SYM_ILL);
    // The first mark after reset only establishes polarity.
    is_v = mark & mark_seen_q & (pol == last_pol_q);

    mark_seen_d  = mark_seen_q | mark;
    last_pol_d   = mark ? pol : last_pol_q;
    v_seen_d     = v_seen_q | is_v;
    last_v_pol_d = is_v ? pol : last_v_pol_q;

    if (mark) begin
      zero_run_d = 3'd0;
    end else if (zero_run_q != ZeroRunSat) begin
      zero_run_d = zero_run_q + 3'd1;
    end else begin
      zero_run_d = zero_run_q;
    end

    err = ill
        | (~mark & (zero_run_q == ZeroRunErr))
        | (is_v & v_seen_q & (pol == last_v_pol_q))
        | (is_v & (|sr_recent));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mark_seen_q  <= 1'b0;
      last_pol_q   <= 1'b0;
      v_seen_q     <= 1'b0;
      last_v_pol_q <= 1'b0;
      zero_run_q   <= 3'd0;
    end else begin
      mark_seen_q  <= mark_seen_d;
      last_pol_q   <= last_pol_d;
      v_seen_q     <= v_seen_d;
      last_v_pol_q <= last_v_pol_d;
      zero_run_q   <= zero_run_d;
    end
  end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 two-rail to NRZ decoder with fixed 4-cycle latency and code-error flag.
// Define HDB3_ERR_CNT_EN to add the saturating err_cnt output.
module hdb3_decoder
  import hdb3_pkg::*;
`ifdef HDB3_ERR_CNT_EN
#(
  parameter int unsigned ERR_CNT_W = 16
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic hdb3_p,
  input  logic hdb3_n,
  output logic data_out,
  output logic data_valid,
  output logic code_err
`ifdef HDB3_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [2:0] FillFull = 3'(HDB3_PIPE_DEPTH);

  logic [3:0] sr_q, sr_d;
  logic [2:0] fill_q, fill_d;
  logic       data_out_q, data_out_d;
  logic       code_err_q, code_err_d;
  logic       mark;
  logic       is_v;
  logic       err;

  hdb3_violation_det u_det (
    .clk       (clk),
    .reset     (reset),
    .sym       ({hdb3_p, hdb3_n}),
    .sr_recent (sr_q[1:0]),
    .mark      (mark),
    .is_v      (is_v),
    .err       (err)
  );

  always_comb begin
    // A V is not data, and it also cancels the slot three symbols back (B or 0).
    sr_d       = {sr_q[2] & ~is_v, sr_q[1], sr_q[0], mark & ~is_v};
    data_out_d = sr_q[3];
    fill_d     = (fill_q == FillFull) ? fill_q : fill_q + 3'd1;
    code_err_d = err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q       <= 4'd0;
      fill_q     <= 3'd0;
      data_out_q <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      data_out_q <= data_out_d;
      code_err_q <= code_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (fill_q == FillFull);
  assign code_err   = code_err_q;

`ifdef HDB3_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (code_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed and randomized checks of hdb3_decoder against a symbol-level reference model.
module tb_hdb3_decoder;
  import hdb3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hdb3_p = 1'b0;
  logic hdb3_n = 1'b0;
  logic data_out;
  logic data_valid;
  logic code_err;
`ifdef HDB3_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] seq[$];
  int         ref_bits[$];
  bit         exp_out[$];
  bit         exp_err[$];

  always #5 clk = ~clk;

  hdb3_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .hdb3_p     (hdb3_p),
    .hdb3_n     (hdb3_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .code_err   (code_err)
`ifdef HDB3_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decoded[i] = mark[i] unless symbol i is a V or symbol i+3 is a V.
  function automatic void build_model();
    bit ms, lp, vs, lvp, m, p, v, e;
    int zeros, n;
    bit mk[$];
    bit vv[$];
    ms = 0; lp = 0; vs = 0; lvp = 0; zeros = 0;
    exp_out.delete();
    exp_err.delete();
    n = seq.size();
    for (int i = 0; i < n; i++) begin
      m = (seq[i] == SYM_POS) || (seq[i] == SYM_NEG);
      p = (seq[i] == SYM_POS);
      v = m && ms && (p == lp);
      e = (seq[i] == SYM_ILL);
      zeros = m ? 0 : zeros + 1;
      if (zeros == HDB3_MAX_ZEROS + 1) e = 1;
      if (v && vs && (p == lvp)) e = 1;
      if (v && i >= 1 && mk[i-1] && !vv[i-1]) e = 1;
      if (v && i >= 2 && mk[i-2] && !vv[i-2]) e = 1;
      if (m) begin
        ms = 1;
        lp = p;
      end
      if (v) begin
        vs = 1;
        lvp = p;
      end
      mk.push_back(m);
      vv.push_back(v);
      exp_err.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      exp_out.push_back(mk[i] && !vv[i] && !((i + 3 < n) && vv[i+3]));
    end
  endfunction

  task automatic assert_reset(input string name);
    {hdb3_p, hdb3_n} = SYM_ZERO;
    reset = 1'b0;
    #1;
    check({name, ":rst_data_out"}, data_out, 1'b0);
    check({name, ":rst_data_valid"}, data_valid, 1'b0);
    check({name, ":rst_code_err"}, code_err, 1'b0);
`ifdef HDB3_ERR_CNT_EN
    check_n({name, ":rst_err_cnt"}, int'(err_cnt), 0);
`endif
  endtask

  // Plays seq (plus 4 flush zeros) from reset release; err pulses are counted over the
  // first n_chk symbols and compared to exp_errs when exp_errs >= 0.
  task automatic run_seq(input string name, input bit do_rst, input int n_chk,
                         input int exp_errs, input bit bits_chk);
    int errs, n, cnt;
    errs = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) seq.push_back(SYM_ZERO);
    build_model();
    n = seq.size();
    if (do_rst) assert_reset(name);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= n; k++) begin
      {hdb3_p, hdb3_n} = seq[k-1];
      @(posedge clk);
      #1;
      check({name, ":code_err"}, code_err, exp_err[k-1]);
      check({name, ":data_valid"}, data_valid, k >= 4);
      check({name, ":data_out"}, data_out, (k >= 5) ? exp_out[k-5] : 1'b0);
      if (bits_chk && k >= 5 && (k - 5) < ref_bits.size())
        check({name, ":nrz"}, data_out, ref_bits[k-5] != 0);
      if (k <= n_chk && code_err) errs++;
      if (k <= n - 1 && exp_err[k-1]) cnt++;
    end
    {hdb3_p, hdb3_n} = SYM_ZERO;
    if (exp_errs >= 0) check_n({name, ":err_pulses"}, errs, exp_errs);
`ifdef HDB3_ERR_CNT_EN
    check_n({name, ":err_cnt"}, int'(err_cnt), cnt);
`endif
  endtask

  function automatic logic [1:0] pol_sym(input int pol);
    return (pol > 0) ? SYM_POS : SYM_NEG;
  endfunction

  // Reference HDB3 encoder: the decoded stream must reproduce ref_bits with no errors.
  task automatic make_encoded(input int nbits);
    int lp, cnt, i;
    seq.delete();
    ref_bits.delete();
    for (int j = 0; j < nbits; j++) ref_bits.push_back(($urandom_range(0, 99) < 35) ? 1 : 0);
    lp = ($urandom_range(0, 1) != 0) ? 1 : -1;
    cnt = 0;
    i = 0;
    while (i < nbits) begin
      if (i + 3 < nbits && ref_bits[i] == 0 && ref_bits[i+1] == 0 && ref_bits[i+2] == 0 &&
          ref_bits[i+3] == 0) begin
        if (cnt % 2 == 1) begin
          seq.push_back(SYM_ZERO);
          seq.push_back(SYM_ZERO);
          seq.push_back(SYM_ZERO);
          seq.push_back(pol_sym(lp));
        end else begin
          lp = -lp;
          seq.push_back(pol_sym(lp));
          seq.push_back(SYM_ZERO);
          seq.push_back(SYM_ZERO);
          seq.push_back(pol_sym(lp));
        end
        cnt = 0;
        i += 4;
      end else if (ref_bits[i] != 0) begin
        lp = -lp;
        seq.push_back(pol_sym(lp));
        cnt++;
        i++;
      end else begin
        seq.push_back(SYM_ZERO);
        i++;
      end
    end
  endtask

  task automatic make_random(input int len);
    int r;
    seq.delete();
    ref_bits.delete();
    for (int j = 0; j < len; j++) begin
      r = $urandom_range(0, 99);
      if (r < 45) seq.push_back(SYM_ZERO);
      else if (r < 70) seq.push_back(SYM_POS);
      else if (r < 95) seq.push_back(SYM_NEG);
      else seq.push_back(SYM_ILL);
    end
  endtask

  initial begin
    int n;

    seq = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS, SYM_NEG};
    ref_bits = '{1, 0, 0, 0, 0, 1};
    run_seq("t1_000v", 1'b1, 6, 0, 1'b1);

    seq = '{SYM_POS, SYM_NEG, SYM_POS, SYM_ZERO, SYM_ZERO, SYM_POS};
    ref_bits = '{1, 1, 0, 0, 0, 0};
    run_seq("t2_b00v", 1'b1, 6, 0, 1'b1);

    seq = '{SYM_NEG, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_NEG};
    ref_bits = '{1, 0, 0, 0, 0};
    run_seq("t3_neg_first", 1'b1, 5, 0, 1'b1);

    seq = '{SYM_POS, SYM_ILL, SYM_NEG};
    ref_bits = '{1, 0, 1};
    run_seq("t4_illegal", 1'b1, 3, 1, 1'b1);

    seq = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO};
    ref_bits.delete();
    run_seq("t5_zero_run", 1'b1, 6, 1, 1'b0);

    seq = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS};
    run_seq("t6_same_v", 1'b1, 8, 1, 1'b0);

    // Reset mid-stream, then a mark that would be a V without the flush.
    seq = '{SYM_POS, SYM_NEG, SYM_POS, SYM_NEG, SYM_POS, SYM_NEG};
    assert_reset("t7_pre");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      {hdb3_p, hdb3_n} = seq[k];
      @(posedge clk);
      #1;
    end
    check("t7_valid_before", data_valid, 1'b1);
    check("t7_data_before", data_out, 1'b1);
    #2;
    {hdb3_p, hdb3_n} = SYM_ZERO;
    reset = 1'b0;
    #1;
    check("t7_data_async", data_out, 1'b0);
    check("t7_valid_async", data_valid, 1'b0);
    check("t7_err_async", code_err, 1'b0);
    seq = '{SYM_NEG, SYM_ZERO, SYM_POS};
    ref_bits = '{1, 0, 1};
    run_seq("t7_post", 1'b0, 3, 0, 1'b1);

    for (int t = 0; t < 3; t++) begin
      make_encoded(80);
      n = seq.size();
      run_seq("enc", 1'b1, n, 0, 1'b1);
    end

    for (int t = 0; t < 4; t++) begin
      make_random(60);
      run_seq("rand", 1'b1, 0, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
